pll_lock_controller: RTL and testbench
======================================

PLL_LOCK_CONTROLLER -- requirements
Module: pll_lock_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESET_CYCLES        16     cycles pll_resetb is held low per acquisition attempt (>=2)
  LOCK_TIMEOUT        4096   cycles allowed for lock per attempt (>=2)
  LOCK_STABLE_CYCLES  64     consecutive synchronized-lock cycles required before RUN (>=1)
  MAX_RETRIES         3      re-acquisition attempts after the first before FAIL (0..15)
  DEFAULT_DELAY       8'h00  reset value of dyn_delay
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk          in   1  single system clock; all logic on rising edge
  reset        in   1  asynchronous, active-high reset
  pll_lock     in   1  PLL LOCK, asynchronous to clk
  pll_resetb   out  1  PLL RESETB, active-low
  pll_bypass   out  1  PLL BYPASS
  dyn_delay    out  8  PLL DYNAMICDELAY value
  delay_valid  in   1  new delay request
  delay_value  in   8  requested delay
  delay_ready  out  1  delay request accepted when delay_valid and delay_ready are both 1
  locked       out  1  PLL locked and stable
  sys_reset    out  1  downstream reset, active-high
  fail         out  1  lock acquisition exhausted
  retry_count  out  4  attempts consumed since the last successful RUN

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchronizer; lock_s denotes its output (2-cycle latency).
REQ-004 The state machine SHALL have five states: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL; one shared cycle counter.
REQ-005 All outputs SHALL be registered, except delay_ready.
REQ-006 RESET_PLL: pll_resetb=0 for exactly RESET_CYCLES cycles; then -> WAIT_LOCK with the counter cleared.
REQ-007 WAIT_LOCK: pll_resetb=1; lock_s=1 -> STABLE with the counter cleared.
REQ-008 WAIT_LOCK, counter reaching LOCK_TIMEOUT-1 without lock_s: retry_count<MAX_RETRIES -> retry_count+1, RESET_PLL; otherwise -> FAIL.
REQ-009 WAIT_LOCK, lock_s=1 on the timeout cycle: lock_s wins (-> STABLE).
REQ-010 STABLE: lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN.
REQ-011 STABLE, any lock_s=0: -> WAIT_LOCK, timeout counter restarted, retry_count unchanged.
REQ-012 RUN entry: locked=1 and retry_count=0, registered with the transition; sys_reset SHALL fall the cycle after entry.
REQ-013 RUN, lock_s=0: locked=0 and sys_reset=1 next cycle; -> RESET_PLL with retry_count=0.
REQ-014 delay_ready SHALL be (state==RUN) && lock_s, so lock loss and a delay request in the same cycle resolve as lock loss, with the request not accepted.
REQ-015 On delay handshake: dyn_delay<=delay_value, locked<=0, -> STABLE; sys_reset SHALL remain 0 during delay re-stabilization.
REQ-016 Lock loss during delay re-stabilization SHALL follow REQ-011; sys_reset SHALL go to 1 only if a RESET_PLL entry occurs.
REQ-017 FAIL (terminal until reset): pll_bypass=1, pll_resetb=0, fail=1, locked=0, sys_reset=0 (system runs on the bypassed reference clock), delay_ready=0.
REQ-018 dyn_delay SHALL change only on a handshake or on reset; it SHALL hold through retries and FAIL.

Reset
REQ-019 While reset=1: state=RESET_PLL, counter=0, pll_resetb=0, pll_bypass=0, dyn_delay=DEFAULT_DELAY, locked=0, sys_reset=1, fail=0, retry_count=0, delay_ready=0, synchronizer flops=0.
REQ-020 Reset asserted mid-operation (any state, including FAIL) SHALL take effect immediately; deassertion restarts acquisition from RESET_PLL.

Verification
REQ-021 Defaults; pll_lock rises 100 cycles after reset release and stays high -> pll_resetb high at cycle 16; locked=1 at 16+(lock latency)+64; sys_reset falls 1 cycle later.
REQ-022 pll_lock held 0, MAX_RETRIES=3 -> four RESET_PLL pulses of 16 cycles, each followed by a 4096-cycle wait; then fail=1, pll_bypass=1, sys_reset=0, retry_count=3.
REQ-023 pll_lock glitches low for 1 cycle at stable-count 40 -> returns to WAIT_LOCK; locked is asserted only after a further full 64 stable cycles; retry_count unchanged.
REQ-024 In RUN, delay_valid=1 with delay_value=8'h5A -> delay_ready=1; dyn_delay=8'h5A next cycle; locked=0 for 64 cycles then 1; sys_reset stays 0 throughout.
REQ-025 In RUN, lock_s falls in the same cycle as delay_valid -> no handshake; dyn_delay unchanged; sys_reset=1; new 16-cycle RESET_PLL pulse.
REQ-026 Assert reset during WAIT_LOCK and during FAIL -> all outputs at REQ-019 values immediately; clean re-acquisition follows.

Source files
------------

// File: rtl/pll_lock_controller.sv
// PLL lock controller: drives the PLL reset pulse, waits for lock with a
// bounded number of retries, qualifies lock stability before releasing the
// downstream reset, and applies dynamic-delay updates through a handshake.
module pll_lock_controller #(
  parameter int unsigned RESET_CYCLES       = 16,
  parameter int unsigned LOCK_TIMEOUT       = 4096,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter logic [7:0]  DEFAULT_DELAY      = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic [7:0] dyn_delay,
  input  logic       delay_valid,
  input  logic [7:0] delay_value,
  output logic       delay_ready,
  output logic       locked,
  output logic       sys_reset,
  output logic       fail,
  output logic [3:0] retry_count
);

  // One shared counter sized for the longest interval it has to time.
  localparam int unsigned CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int          CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [3:0]       r_retry;
  logic [3:0]       w_next_retry;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_lock_s;
  logic             w_delay_ready;
  logic             w_handshake;
  logic             w_next_sys_reset;

  logic             r_pll_resetb;
  logic             r_pll_bypass;
  logic [7:0]       r_dyn_delay;
  logic             r_locked;
  logic             r_sys_reset;
  logic             r_fail;

  assign w_lock_s      = r_sync2;
  // A request is only accepted while running on a lock that is still present,
  // so a lock loss in the same cycle always wins over the request.
  assign w_delay_ready = (r_state == S_RUN) && w_lock_s;
  assign w_handshake   = delay_valid && w_delay_ready;

  assign pll_resetb  = r_pll_resetb;
  assign pll_bypass  = r_pll_bypass;
  assign dyn_delay   = r_dyn_delay;
  assign delay_ready = w_delay_ready;
  assign locked      = r_locked;
  assign sys_reset   = r_sys_reset;
  assign fail        = r_fail;
  assign retry_count = r_retry;

  // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_retry = r_retry;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == RESET_LAST) begin
          w_next_state = S_WAIT_LOCK;
          w_next_cnt   = CNT_ZERO;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next_state = S_STABLE;
          w_next_cnt   = CNT_ZERO;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next_cnt = CNT_ZERO;
          if (r_retry < RETRY_MAX) begin
            w_next_retry = r_retry + 4'd1;
            w_next_state = S_RESET_PLL;
          end else begin
            w_next_state = S_FAIL;
          end
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!w_lock_s) begin
          w_next_state = S_WAIT_LOCK;
          w_next_cnt   = CNT_ZERO;
        end else if (r_cnt == STABLE_LAST) begin
          w_next_state = S_RUN;
          w_next_cnt   = CNT_ZERO;
          w_next_retry = 4'd0;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_next_state = S_RESET_PLL;
          w_next_cnt   = CNT_ZERO;
          w_next_retry = 4'd0;
        end else if (w_handshake) begin
          w_next_state = S_STABLE;
          w_next_cnt   = CNT_ZERO;
        end else begin
          w_next_cnt = CNT_ZERO;
        end
      end
      S_FAIL: begin
        w_next_state = S_FAIL;
      end
      default: begin
        w_next_state = S_RESET_PLL;
        w_next_cnt   = CNT_ZERO;
        w_next_retry = 4'd0;
      end
    endcase
  end

  // Downstream reset: raised on any PLL reset, dropped once running, and
  // otherwise held so delay re-stabilization never disturbs the system.
  always_comb begin
    w_next_sys_reset = r_sys_reset;
    case (w_next_state)
      S_RESET_PLL: w_next_sys_reset = 1'b1;
      S_FAIL:      w_next_sys_reset = 1'b0;
      default: begin
        if (r_state == S_RUN) begin
          w_next_sys_reset = 1'b0;
        end else begin
          w_next_sys_reset = r_sys_reset;
        end
      end
    endcase
  end

  // State, counter and retry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESET_PLL;
      r_cnt   <= CNT_ZERO;
      r_retry <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_retry <= w_next_retry;
    end
  end

  // Registered outputs, decoded from the state being entered so they change
  // together with the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pll_resetb <= 1'b0;
      r_pll_bypass <= 1'b0;
      r_locked     <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_fail       <= 1'b0;
    end else begin
      r_pll_resetb <= (w_next_state == S_WAIT_LOCK) || (w_next_state == S_STABLE) ||
                      (w_next_state == S_RUN);
      r_pll_bypass <= (w_next_state == S_FAIL);
      r_locked     <= (w_next_state == S_RUN);
      r_sys_reset  <= w_next_sys_reset;
      r_fail       <= (w_next_state == S_FAIL);
    end
  end

  // Dynamic delay only moves on an accepted request; it survives retries and FAIL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dyn_delay <= DEFAULT_DELAY;
    end else if (w_handshake) begin
      r_dyn_delay <= delay_value;
    end else begin
      r_dyn_delay <= r_dyn_delay;
    end
  end

endmodule

// File: tb/tb_pll_lock_controller.sv
// Testbench for pll_lock_controller: randomized lock timing, glitches and
// delay requests, with expected event cycles derived arithmetically.
module tb_pll_lock_controller;

  localparam int RC = 16;    // reset pulse length
  localparam int LT = 4096;  // lock timeout
  localparam int LS = 64;    // stable cycles
  localparam int MR = 3;     // retries

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       delay_valid = 1'b0;
  logic [7:0] delay_value = 8'h00;
  logic       pll_resetb, pll_bypass, delay_ready, locked, sys_reset, fail;
  logic [7:0] dyn_delay;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pll_lock_controller dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock),
    .pll_resetb(pll_resetb), .pll_bypass(pll_bypass), .dyn_delay(dyn_delay),
    .delay_valid(delay_valid), .delay_value(delay_value), .delay_ready(delay_ready),
    .locked(locked), .sys_reset(sys_reset), .fail(fail), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // Reset pulse; cycle numbering restarts at the release point.
  task automatic apply_reset();
    reset = 1'b1;
    pll_lock = 1'b0;
    delay_valid = 1'b0;
    delay_value = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  // Edge at which the controller leaves WAIT_LOCK for STABLE: lock driven
  // after edge p is visible to the FSM at edge p+3 (two synchronizer flops),
  // and WAIT_LOCK (entered at edge wl) first looks at it on edge wl+1.
  function automatic int lock_seen_edge(int p, int wl);
    return (p + 3 > wl + 1) ? p + 3 : wl + 1;
  endfunction

  // Bring the controller into RUN with lock present from release.
  task automatic acquire();
    apply_reset();
    pll_lock = 1'b1;
    while (cyc < lock_seen_edge(0, RC) + LS) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 8;
    if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL reset_resetb got=%b exp=0", pll_resetb); end
    if (pll_bypass !== 1'b0) begin n_fail++; $display("FAIL reset_bypass got=%b exp=0", pll_bypass); end
    if (dyn_delay !== 8'h00) begin n_fail++; $display("FAIL reset_delay got=%h exp=00", dyn_delay); end
    if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
    if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sysrst got=%b exp=1", sys_reset); end
    if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail got=%b exp=0", fail); end
    if (retry_count !== 4'd0) begin n_fail++; $display("FAIL reset_retry got=%0d exp=0", retry_count); end
    if (delay_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", delay_ready); end
  endtask

  task automatic test_acquire();
    int p, lk;
    for (int t = 0; t < 4; t++) begin
      p = (t == 0) ? 100 : int'($urandom_range(0, 250));
      apply_reset();
      lk = lock_seen_edge(p, RC) + LS;
      while (cyc < lk + 4) begin
        if (cyc == p) pll_lock = 1'b1;
        tick();
        n_checks += 5;
        if (pll_resetb !== (cyc >= RC)) begin n_fail++; $display("FAIL acq_resetb p=%0d cyc=%0d got=%b", p, cyc, pll_resetb); end
        if (locked !== (cyc >= lk)) begin n_fail++; $display("FAIL acq_locked p=%0d cyc=%0d got=%b exp=%b", p, cyc, locked, cyc >= lk); end
        if (sys_reset !== (cyc < lk + 1)) begin n_fail++; $display("FAIL acq_sysrst p=%0d cyc=%0d got=%b exp=%b", p, cyc, sys_reset, cyc < lk + 1); end
        if (delay_ready !== (cyc >= lk)) begin n_fail++; $display("FAIL acq_ready p=%0d cyc=%0d got=%b exp=%b", p, cyc, delay_ready, cyc >= lk); end
        if ({fail, pll_bypass, retry_count} !== 6'd0) begin n_fail++; $display("FAIL acq_fail_retry cyc=%0d got=%b%b%0d exp=000", cyc, fail, pll_bypass, retry_count); end
      end
    end
  endtask

  task automatic test_glitch();
    int p, g, l, x, lk;
    for (int t = 0; t < 4; t++) begin
      g = (t == 0) ? 40 : int'($urandom_range(1, LS));
      p = int'($urandom_range(0, 60));
      apply_reset();
      l  = lock_seen_edge(p, RC);
      x  = l + g - 3;            // lock_s is low exactly at STABLE edge l+g
      lk = l + g + 1 + LS;       // full stable run restarts one edge later
      while (cyc < lk + 3) begin
        if (cyc == p) pll_lock = 1'b1;
        if (cyc == x) pll_lock = 1'b0;
        if (cyc == x + 1) pll_lock = 1'b1;
        tick();
        n_checks += 3;
        if (locked !== (cyc >= lk)) begin n_fail++; $display("FAIL glitch_locked g=%0d cyc=%0d got=%b exp=%b", g, cyc, locked, cyc >= lk); end
        if (sys_reset !== (cyc < lk + 1)) begin n_fail++; $display("FAIL glitch_sysrst g=%0d cyc=%0d got=%b", g, cyc, sys_reset); end
        if (retry_count !== 4'd0) begin n_fail++; $display("FAIL glitch_retry cyc=%0d got=%0d exp=0", cyc, retry_count); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int h;
    logic [7:0] val;
    logic [7:0] exp_delay;
    acquire();
    exp_delay = 8'h00;
    for (int k = 0; k < 3; k++) begin
      val = (k == 0) ? 8'h5A : 8'($urandom);
      repeat ($urandom_range(2, 5)) tick();
      h = cyc;
      delay_valid = 1'b1;
      delay_value = val;
      n_checks++;
      if (delay_ready !== 1'b1) begin n_fail++; $display("FAIL dly_ready_run cyc=%0d got=%b exp=1", cyc, delay_ready); end
      tick();
      exp_delay = val;
      delay_value = ~val;   // still valid, but not in RUN: must be ignored
      n_checks += 2;
      if (dyn_delay !== exp_delay) begin n_fail++; $display("FAIL dly_value cyc=%0d got=%h exp=%h", cyc, dyn_delay, exp_delay); end
      if (locked !== 1'b0) begin n_fail++; $display("FAIL dly_unlock cyc=%0d got=%b exp=0", cyc, locked); end
      while (cyc < h + 1 + LS) begin
        if (cyc == h + LS - 1) delay_valid = 1'b0;
        tick();
        n_checks += 4;
        if (locked !== (cyc >= h + 1 + LS)) begin n_fail++; $display("FAIL dly_locked cyc=%0d got=%b", cyc, locked); end
        if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL dly_sysrst cyc=%0d got=%b exp=0", cyc, sys_reset); end
        if (dyn_delay !== exp_delay) begin n_fail++; $display("FAIL dly_hold cyc=%0d got=%h exp=%h", cyc, dyn_delay, exp_delay); end
        if (delay_ready !== (cyc >= h + 1 + LS)) begin n_fail++; $display("FAIL dly_ready cyc=%0d got=%b", cyc, delay_ready); end
      end
    end
  endtask

  task automatic test_loss_with_request();
    int x;
    acquire();
    repeat (6) tick();
    x = cyc;
    pll_lock = 1'b0;
    tick();
    tick();
    delay_valid = 1'b1;
    delay_value = 8'hC3;
    n_checks++;
    if (delay_ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready cyc=%0d got=%b exp=0", cyc, delay_ready); end
    tick();
    delay_valid = 1'b0;
    n_checks++;
    if ({sys_reset, locked, pll_resetb, dyn_delay, retry_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'd0})
      begin n_fail++; $display("FAIL loss_exit cyc=%0d got=%b%b%b %h %0d exp=100 00 0", cyc, sys_reset, locked, pll_resetb, dyn_delay, retry_count); end
    while (cyc < x + 88) begin
      if (cyc == x + 10) pll_lock = 1'b1;
      tick();
      n_checks += 3;
      if (pll_resetb !== (cyc >= x + 19)) begin n_fail++; $display("FAIL loss_pulse cyc=%0d got=%b", cyc, pll_resetb); end
      if (locked !== (cyc >= x + 84)) begin n_fail++; $display("FAIL loss_relock cyc=%0d got=%b", cyc, locked); end
      if (sys_reset !== (cyc < x + 85)) begin n_fail++; $display("FAIL loss_sysrst cyc=%0d got=%b", cyc, sys_reset); end
    end
  endtask

  // Lock loss while re-stabilizing after a delay change: back to WAIT_LOCK,
  // system reset untouched, delay kept.
  task automatic test_restab_loss();
    acquire();
    while (cyc < 85) tick();
    delay_valid = 1'b1;
    delay_value = 8'h3C;
    tick();
    delay_valid = 1'b0;
    while (cyc < 90) tick();
    pll_lock = 1'b0;
    while (cyc < 120) begin
      tick();
      n_checks += 2;
      if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL restab_sysrst cyc=%0d got=%b exp=0", cyc, sys_reset); end
      if (dyn_delay !== 8'h3C) begin n_fail++; $display("FAIL restab_delay cyc=%0d got=%h exp=3c", cyc, dyn_delay); end
    end
    n_checks++;
    if ({pll_resetb, locked, retry_count} !== {1'b1, 1'b0, 4'd0})
      begin n_fail++; $display("FAIL restab_wait cyc=%0d got=%b%b%0d exp=10 0", cyc, pll_resetb, locked, retry_count); end
  endtask

  task automatic test_fail();
    int period, fe, er;
    logic [8:0] obs, expv;
    logic bad;
    period = RC + LT;
    fe = (MR + 1) * period;
    bad = 1'b0;
    apply_reset();
    while (cyc < fe + 20) begin
      tick();
      er = (cyc / period < MR) ? cyc / period : MR;
      obs  = {pll_resetb, pll_bypass, fail, sys_reset, locked, retry_count};
      expv = {(cyc < fe) && (cyc % period >= RC), cyc >= fe, cyc >= fe, cyc < fe, 1'b0, 4'(er)};
      if (!bad) begin
        n_checks++;
        if (obs !== expv) begin
          n_fail++; bad = 1'b1;
          $display("FAIL retry_seq cyc=%0d got=%b exp=%b", cyc, obs, expv);
        end
      end
    end
    pll_lock = 1'b1;
    delay_valid = 1'b1;
    delay_value = 8'hA5;
    repeat (10) begin
      tick();
      n_checks++;
      if ({delay_ready, dyn_delay, fail, pll_bypass, pll_resetb, locked, sys_reset, retry_count} !==
          {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3})
        begin n_fail++; $display("FAIL fail_hold cyc=%0d got=%b %h %b%b%b%b%b %0d", cyc, delay_ready, dyn_delay, fail, pll_bypass, pll_resetb, locked, sys_reset, retry_count); end
    end
    delay_valid = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs at once; afterwards a
  // clean acquisition follows.
  task automatic test_reset_midop(input string where);
    logic [17:0] rv;
    int lk;
    rv = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pll_resetb, pll_bypass, dyn_delay, locked, sys_reset, fail, retry_count, delay_ready} !== rv)
      begin n_fail++; $display("FAIL midrst_%s got=%b exp=%b", where, {pll_resetb, pll_bypass, dyn_delay, locked, sys_reset, fail, retry_count, delay_ready}, rv); end
    tick();
    tick();
    n_checks++;
    if ({pll_resetb, pll_bypass, dyn_delay, locked, sys_reset, fail, retry_count, delay_ready} !== rv)
      begin n_fail++; $display("FAIL midrst_hold_%s got=%b exp=%b", where, {pll_resetb, pll_bypass, dyn_delay, locked, sys_reset, fail, retry_count, delay_ready}, rv); end
    reset = 1'b0;
    cyc = 0;
    pll_lock = 1'b1;
    delay_valid = 1'b0;
    lk = lock_seen_edge(0, RC) + LS;
    while (cyc < lk + 3) begin
      tick();
      n_checks += 3;
      if (pll_resetb !== (cyc >= RC)) begin n_fail++; $display("FAIL reacq_resetb_%s cyc=%0d got=%b", where, cyc, pll_resetb); end
      if (locked !== (cyc >= lk)) begin n_fail++; $display("FAIL reacq_locked_%s cyc=%0d got=%b", where, cyc, locked); end
      if ({sys_reset, fail, pll_bypass} !== {cyc < lk + 1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reacq_misc_%s cyc=%0d got=%b%b%b", where, cyc, sys_reset, fail, pll_bypass); end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_glitch();
    test_back_to_back();
    test_loss_with_request();
    test_restab_loss();
    test_reset_midop("wait_lock");
    test_fail();
    test_reset_midop("fail");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
